key_conditioner: RTL

- Conditions raw, bouncing, active-low pushbuttons before they reach the control inputs of the 8-bit logic processor (LoadA, LoadB, Execute).
- Per key: 2-flop synchronizer, debounce FSM, debounced level output, one-cycle press/release pulses.
- Sits directly upstream of the processor's control logic. The processor gets clean levels, so one physical press yields exactly one Load or Execute.

---
 rtl/key_conditioner.sv | 134 +++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// key_conditioner
// Cleans up raw active-low pushbuttons before they reach the LoadA / LoadB /
// Execute controls of the 8-bit logic processor. Each key gets a 2-flop
// synchronizer, a debounce FSM, a registered debounced level, and one-cycle
// press/release pulses. Keys are fully independent of each other.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// IDLE         | key released and stable, Key_level = 0
// PRESS_WAIT   | synced key reads pressed, counting stable samples, level 0
// PRESSED      | key pressed and stable, Key_level = 1
// RELEASE_WAIT | synced key reads released, counting stable samples, level 1
//
// A level change needs DEBOUNCE_CYCLES+1 consecutive agreeing synchronized
// samples: one sample to leave the stable state, then DEBOUNCE_CYCLES-1
// counter increments, and the final sample at cnt = DEBOUNCE_CYCLES-1.
// Because the wait states exit at that count, cnt never wraps.

module key_conditioner #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] Key_n,
    output logic [NUM_KEYS-1:0] Key_level,
    output logic [NUM_KEYS-1:0] Press_pulse,
    output logic [NUM_KEYS-1:0] Release_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;

    // Two-flop synchronizer; inversion up front so everything downstream is active-high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~Key_n;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             level_nxt;
        logic             press_nxt;
        logic             release_nxt;
        logic             s;

        assign s = sync2[i];

        // State, counter and registered outputs; reset drops everything with no pulse.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                state            <= IDLE;
                cnt              <= '0;
                Key_level[i]     <= 1'b0;
                Press_pulse[i]   <= 1'b0;
                Release_pulse[i] <= 1'b0;
            end else begin
                state            <= state_nxt;
                cnt              <= cnt_nxt;
                Key_level[i]     <= level_nxt;
                Press_pulse[i]   <= press_nxt;
                Release_pulse[i] <= release_nxt;
            end
        end

        // Next state and counter: any disagreeing sample aborts a wait.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            unique case (state)
                IDLE: begin
                    if (s) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_nxt = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = PRESSED;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_nxt = PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Output decode, registered above so pulses appear the cycle after the qualifying edge.
        always_comb begin
            level_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
            press_nxt   = (state == PRESS_WAIT) && s && (cnt == CNT_LAST);
            release_nxt = (state == RELEASE_WAIT) && !s && (cnt == CNT_LAST);
        end
    end

endmodule
